// File: rtl/ascii_to_ps2_tx_if.sv
// ascii_to_ps2_tx_if: request/status bundle (wr_ascii, din in; tx_ready, ps2c, ps2d, tx_done_tick, err_tick out of the transmitter)
interface ascii_to_ps2_tx_if;
  logic       wr_ascii;
  logic [7:0] din;
  logic       tx_ready;
  logic       ps2c;
  logic       ps2d;
  logic       tx_done_tick;
  logic       err_tick;
  modport master (output wr_ascii, din, input tx_ready, ps2c, ps2d, tx_done_tick, err_tick);
  modport slave  (input wr_ascii, din, output tx_ready, ps2c, ps2d, tx_done_tick, err_tick);
endinterface

// File: rtl/ascii_to_ps2_tx.sv
// ascii_to_ps2_tx: maps an ASCII char to a set-2 scan code and sends make, F0, make on ps2c/ps2d (ports: clk, reset, tx = request/status bundle)
module ascii_to_ps2_tx #(
  parameter int HALF_TICKS = 2500,
  parameter int GAP_TICKS  = 5000
) (
  input logic              clk,
  input logic              reset,
  ascii_to_ps2_tx_if.slave tx
);
  localparam int MAXT = HALF_TICKS > GAP_TICKS ? HALF_TICKS : GAP_TICKS;
  localparam int W    = MAXT > 1 ? $clog2(MAXT) : 1;
  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;
  state_t       r_state;
  logic [W-1:0] r_tick;
  logic [3:0]   r_bit;
  logic [1:0]   r_byte;
  logic [7:0]   r_code;
  logic         r_ps2c, r_ps2d, r_ready, r_done, r_err;
  logic [7:0]   w_up, w_code, w_byte;
  logic         w_ok, w_half_end, w_gap_end, w_last_end;
  logic [10:0]  w_frame;
  assign w_up = (tx.din >= 8'h61 && tx.din <= 8'h7a) ? tx.din - 8'h20 : tx.din;
  always_comb begin
    w_code = 8'h00;
    w_ok   = 1'b1;
    case (w_up)
      8'h30: w_code = 8'h45;
      8'h31: w_code = 8'h16;
      8'h32: w_code = 8'h1E;
      8'h33: w_code = 8'h26;
      8'h34: w_code = 8'h25;
      8'h35: w_code = 8'h2E;
      8'h36: w_code = 8'h36;
      8'h37: w_code = 8'h3D;
      8'h38: w_code = 8'h3E;
      8'h39: w_code = 8'h46;
      8'h41: w_code = 8'h1C;
      8'h42: w_code = 8'h32;
      8'h43: w_code = 8'h21;
      8'h44: w_code = 8'h23;
      8'h45: w_code = 8'h24;
      8'h46: w_code = 8'h2B;
      8'h47: w_code = 8'h34;
      8'h48: w_code = 8'h33;
      8'h49: w_code = 8'h43;
      8'h4A: w_code = 8'h3B;
      8'h4B: w_code = 8'h42;
      8'h4C: w_code = 8'h4B;
      8'h4D: w_code = 8'h3A;
      8'h4E: w_code = 8'h31;
      8'h4F: w_code = 8'h44;
      8'h50: w_code = 8'h4D;
      8'h51: w_code = 8'h15;
      8'h52: w_code = 8'h2D;
      8'h53: w_code = 8'h1B;
      8'h54: w_code = 8'h2C;
      8'h55: w_code = 8'h3C;
      8'h56: w_code = 8'h2A;
      8'h57: w_code = 8'h1D;
      8'h58: w_code = 8'h22;
      8'h59: w_code = 8'h35;
      8'h5A: w_code = 8'h1A;
      8'h60: w_code = 8'h0E;
      8'h2D: w_code = 8'h4E;
      8'h3D: w_code = 8'h55;
      8'h5B: w_code = 8'h54;
      8'h5D: w_code = 8'h5B;
      8'h5C: w_code = 8'h5D;
      8'h3B: w_code = 8'h4C;
      8'h27: w_code = 8'h52;
      8'h2C: w_code = 8'h41;
      8'h2E: w_code = 8'h49;
      8'h2F: w_code = 8'h4A;
      8'h20: w_code = 8'h29;
      8'h0D: w_code = 8'h5A;
      8'h08: w_code = 8'h66;
      default: w_ok = 1'b0;
    endcase
  end
  assign w_byte     = r_byte == 2'd1 ? 8'hF0 : r_code;
  assign w_frame    = {1'b1, ~^w_byte, w_byte, 1'b0};
  assign w_half_end = r_tick == W'(HALF_TICKS - 1);
  assign w_gap_end  = r_tick == W'(GAP_TICKS - 1);
  // the final gap cycle doubles as the idle/ready cycle so a new key can follow with no extra gap
  assign w_last_end = r_tick == W'(GAP_TICKS - 2);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_code  <= '0;
      r_ps2c  <= 1'b1;
      r_ps2d  <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_tick <= r_tick + 1'b1;
      case (r_state)
        IDLE: begin
          r_tick <= '0;
          if (tx.wr_ascii && w_ok) begin
            r_code  <= w_code;
            r_state <= BIT_HI;
            r_bit   <= '0;
            r_byte  <= '0;
            r_ready <= 1'b0;
            r_ps2d  <= 1'b0;
          end else if (tx.wr_ascii) begin
            r_err <= 1'b1;
          end
        end
        BIT_HI: if (w_half_end) begin
          r_tick  <= '0;
          r_state <= BIT_LO;
          r_ps2c  <= 1'b0;
        end
        BIT_LO: if (w_half_end) begin
          r_tick <= '0;
          r_ps2c <= 1'b1;
          if (r_bit == 4'd10) begin
            r_ps2d <= 1'b1;
            if (r_byte == 2'd2 && GAP_TICKS == 1) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end else begin
              r_state <= GAP;
            end
          end else begin
            r_bit   <= r_bit + 4'd1;
            r_ps2d  <= w_frame[r_bit + 4'd1];
            r_state <= BIT_HI;
          end
        end
        GAP: if (r_byte == 2'd2 && w_last_end) begin
          r_tick  <= '0;
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
        end else if (r_byte != 2'd2 && w_gap_end) begin
          r_tick  <= '0;
          r_byte  <= r_byte + 2'd1;
          r_bit   <= '0;
          r_ps2d  <= 1'b0;
          r_state <= BIT_HI;
        end
      endcase
    end
  end
  assign tx.tx_ready     = r_ready;
  assign tx.ps2c         = r_ps2c;
  assign tx.ps2d         = r_ps2d;
  assign tx.tx_done_tick = r_done;
  assign tx.err_tick     = r_err;
endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// tb_ascii_to_ps2_tx: drives ASCII requests and decodes the PS/2 lines with a host model against a table-driven reference
module tb_ascii_to_ps2_tx;
  localparam int H = 4, G = 8, KEY = 3 * (22 * H + G);
  logic clk = 1'b0, reset = 1'b1;
  ascii_to_ps2_tx_if bus ();
  ascii_to_ps2_tx #(.HALF_TICKS(H), .GAP_TICKS(G)) dut (.clk(clk), .reset(reset), .tx(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc = 0;
  int n_fall = 0, n_done = 0, n_err = 0, stab_bad = 0;
  logic [7:0] q_rx[$], q_exp[$];
  logic [7:0] ref_code[256];
  logic       ref_ok[256];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    logic prev_c, prev_d;
    logic [10:0] fr;
    int nbits;
    prev_c = 1'b1;
    prev_d = 1'b1;
    nbits  = 0;
    fr     = '0;
    forever begin
      @(negedge clk);
      if (bus.ps2d !== prev_d && bus.ps2c === 1'b0) stab_bad++;
      if (reset) nbits = 0;
      else if (prev_c === 1'b1 && bus.ps2c === 1'b0) begin
        n_fall++;
        fr[nbits] = bus.ps2d;
        nbits++;
        if (nbits == 11) begin
          check("start_bit", 32'(fr[0]), 0);
          check("stop_bit", 32'(fr[10]), 1);
          check("odd_parity", 32'(^fr[9:1]), 1);
          q_rx.push_back(fr[8:1]);
          nbits = 0;
        end
      end
      if (bus.tx_done_tick === 1'b1) n_done++;
      if (bus.err_tick === 1'b1) n_err++;
      prev_c = bus.ps2c;
      prev_d = bus.ps2d;
    end
  end
  task automatic req(input logic [7:0] a);
    acc = cyc;
    bus.din = a;
    bus.wr_ascii = 1'b1;
    @(negedge clk);
    bus.wr_ascii = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int k = 0; k < KEY + 50 && bus.tx_done_tick !== 1'b1; k++) @(negedge clk);
    check({tag, "_latency"}, cyc - acc, KEY);
    check({tag, "_ready_at_done"}, 32'(bus.tx_ready), 1);
  endtask
  task automatic key(input logic [7:0] a, input string tag);
    q_exp.push_back(ref_code[a]);
    q_exp.push_back(8'hF0);
    q_exp.push_back(ref_code[a]);
    req(a);
    wait_done(tag);
  endtask
  task automatic cmp_bytes(input string tag);
    check({tag, "_nbytes"}, q_rx.size(), q_exp.size());
    for (int i = 0; i < q_rx.size() && i < q_exp.size(); i++) check({tag, "_byte"}, q_rx[i], q_exp[i]);
    q_rx.delete();
    q_exp.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] dig[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] let_c[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
                              8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [15:0] misc[14] = '{16'h600E, 16'h2D4E, 16'h3D55, 16'h5B54, 16'h5D5B, 16'h5C5D, 16'h3B4C,
                              16'h2752, 16'h2C41, 16'h2E49, 16'h2F4A, 16'h2029, 16'h0D5A, 16'h0866};
    int bad, d0, e0, f0;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      ref_ok[i] = 1'b0;
      ref_code[i] = 8'h00;
    end
    for (int i = 0; i < 10; i++) begin
      ref_ok[48 + i] = 1'b1;
      ref_code[48 + i] = dig[i];
    end
    for (int i = 0; i < 26; i++) begin
      ref_ok[65 + i] = 1'b1;
      ref_code[65 + i] = let_c[i];
      ref_ok[97 + i] = 1'b1;
      ref_code[97 + i] = let_c[i];
    end
    for (int i = 0; i < 14; i++) begin
      ref_ok[misc[i][15:8]] = 1'b1;
      ref_code[misc[i][15:8]] = misc[i][7:0];
    end
    bus.wr_ascii = 1'b0;
    bus.din = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.tx_ready !== 1'b1 || bus.ps2c !== 1'b1 || bus.ps2d !== 1'b1) bad++;
    end
    check("idle_lines", bad, 0);
    check("idle_ticks", n_done + n_err + n_fall, 0);
    @(negedge clk);
    key(8'h41, "A");
    cmp_bytes("A");
    @(negedge clk);
    d0 = n_done;
    key(8'h61, "a");
    key(8'h0D, "cr");
    @(negedge clk);
    cmp_bytes("a_cr");
    check("a_cr_done_count", n_done - d0, 2);
    e0 = n_err;
    f0 = n_fall;
    req(8'h7E);
    check("err_tick", 32'(bus.err_tick), 1);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.tx_ready !== 1'b1) bad++;
    end
    check("err_ready_held", bad, 0);
    check("err_count", n_err - e0, 1);
    check("err_no_clock", n_fall - f0, 0);
    @(negedge clk);
    d0 = n_done;
    e0 = n_err;
    q_exp = '{8'h1C, 8'hF0, 8'h1C};
    req(8'h41);
    repeat (50) @(negedge clk);
    bus.din = 8'h31;
    bus.wr_ascii = 1'b1;
    @(negedge clk);
    bus.wr_ascii = 1'b0;
    wait_done("ignore");
    repeat (300) @(negedge clk);
    check("ignore_done_count", n_done - d0, 1);
    check("ignore_err_count", n_err - e0, 0);
    cmp_bytes("ignore");
    @(negedge clk);
    d0 = n_done;
    q_exp = '{8'h1C};
    req(8'h41);
    while (cyc < acc + 140) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ps2c", 32'(bus.ps2c), 1);
    check("rst_ps2d", 32'(bus.ps2d), 1);
    check("rst_ready", 32'(bus.tx_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_no_done", n_done - d0, 0);
    cmp_bytes("rst");
    @(negedge clk);
    key(8'h20, "space");
    cmp_bytes("space");
    repeat (8) begin
      a = 8'($urandom_range(0, 127));
      @(negedge clk);
      if (ref_ok[a]) key(a, "rnd");
      else begin
        req(a);
        check("rnd_err_tick", 32'(bus.err_tick), 1);
        check("rnd_err_ready", 32'(bus.tx_ready), 1);
      end
      cmp_bytes("rnd");
    end
    check("ps2d_stable_while_clk_low", stab_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ascii_to_ps2_tx.md
Name: ascii_to_ps2_tx

Overview:
- Keyboard emulator transmitter: accepts one ASCII character per request and converts it to a PS/2 set-2 scan code.
- Serialises that code as a device-to-host keystroke on the PS/2 clock/data lines: make code, then break prefix F0, then the code again.
- Inverse of the keyboard receive path's scan-code-to-ASCII conversion; used to drive a PS/2 host (or our own receiver) from a UART/test source.

Parameters:
- HALF_TICKS, 2500, clk cycles per PS/2 clock half-period (100 MHz -> 20 kHz PS/2 clock).
- GAP_TICKS, 5000, idle clk cycles after each byte's stop bit, lines high.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- wr_ascii  input  1  request strobe; accepted only when tx_ready=1
- din  input  8  ASCII character, sampled on the accept cycle
- tx_ready  output  1  high when idle and able to accept
- ps2c  output  1  PS/2 clock line (push-pull model, idle 1)
- ps2d  output  1  PS/2 data line (push-pull model, idle 1)
- tx_done_tick  output  1  one-cycle pulse when the full 3-byte sequence completes
- err_tick  output  1  one-cycle pulse when din has no mapping

Behaviour:
- Reset: tx_ready=1, ps2c=1, ps2d=1, tx_done_tick=0, err_tick=0, FSM=IDLE. Reset in any state aborts immediately; outputs take reset values the next cycle. No partial frame resumes.
- Lookup (combinational, registered at accept):
  - '0'-'9' -> 45,16,1E,26,25,2E,36,3D,3E,46.
  - 'A'-'Z' and 'a'-'z' (same codes, no shift emitted) -> 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - Punctuation: '`'->0E, '-'->4E, '='->55, '['->54, ']'->5B, '\'->5D, ';'->4C, '''->52, ','->41, '.'->49, '/'->4A.
  - Control: space(20)->29, CR(0D)->5A, BS(08)->66.
  - All else unmapped.
- Accept: wr_ascii=1 and tx_ready=1 in cycle N.
  - Mapped: tx_ready=0 from N+1; transmission starts.
  - Unmapped: err_tick=1 in N+1, tx_ready stays 1, lines untouched.
  - wr_ascii while tx_ready=0 is ignored (no queueing, no error).
- FSM: IDLE -> BIT_HI -> BIT_LO -> (next bit BIT_HI | GAP) -> (next byte BIT_HI | IDLE).
- Byte sequence: index 0 = code, 1 = F0, 2 = code.
- Frame: 11 bits in order: start 0, data[0]..data[7] (LSB first), odd parity (ones in data+parity is odd), stop 1.
- Per bit:
  - BIT_HI: ps2d = bit value, ps2c=1, for HALF_TICKS cycles.
  - BIT_LO: ps2c=0, ps2d held, for HALF_TICKS cycles.
  - ps2d changes only while ps2c=1.
- First BIT_HI begins at N+1. After bit 10's BIT_LO: GAP with ps2c=1, ps2d=1 for GAP_TICKS cycles.
- Cycle counts: frame = 22*HALF_TICKS cycles; full keystroke = 3*(22*HALF_TICKS + GAP_TICKS) cycles.
- Completion: at the end of the third GAP, tx_done_tick=1 and tx_ready=1 in the same cycle. A new wr_ascii is accepted in that cycle.
- Counters:
  - Tick counter width is clog2(max(HALF_TICKS, GAP_TICKS)); it resets to 0 at each phase entry and the phase ends at count = limit-1.
  - Bit index 0..10, byte index 0..2; no wrap beyond.
- Outputs are registered; no combinational path from inputs to ps2c/ps2d.

Test Plan (HALF_TICKS=4, GAP_TICKS=8; keystroke = 3*(88+8) = 288 cycles):
- Reset released, no stimulus -> tx_ready=1, ps2c=1, ps2d=1 indefinitely, no ticks.
- din=0x41 ('A') -> host model sampling ps2d on ps2c falling edges decodes 1C (parity 0), F0 (parity 1), 1C. Every stop bit =1. tx_done_tick exactly 288 cycles after accept.
- din=0x61 ('a') then 0x0D -> bytes 1C,F0,1C then 5A,F0,5A. Second request is issued in the tx_done_tick cycle and accepted; no idle gap beyond GAP_TICKS.
- din=0x7E -> err_tick pulse in the next cycle, ps2c never toggles, tx_ready stays 1.
- wr_ascii with din=0x31 pulsed mid-frame of 'A' -> ignored; only the 1C,F0,1C sequence appears, with a single tx_done_tick.
- reset asserted during bit 5 of F0 byte -> next cycle ps2c=1, ps2d=1, tx_ready=1, no tx_done_tick. A following din=0x20 yields 29,F0,29.
